// File: rtl/bcd_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_driver
// Description : Serial double-dabble binary-to-BCD converter feeding four
//               7-segment decoders, with leading-zero blanking and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_driver #(
    parameter int WIDTH = 14
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [WIDTH-1:0] iVALUE,
    input  logic             iSTART,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [3:0]       oDIG3,
    output logic [3:0]       oDIG2,
    output logic [3:0]       oDIG1,
    output logic [3:0]       oDIG0,
    output logic [3:0]       oBLANK,
    output logic             oOVF
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_CONV = 2'd1;
    localparam logic [1:0]       c_LOAD = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_busy;

    logic [WIDTH-1:0] r_bin;
    logic [15:0]      r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_ovf_in;
    logic [14:0]      w_bcd_adj;

    logic [15:0]      r_dig;
    logic [3:0]       r_blank;
    logic             r_ovf_out;
    logic             r_done;

    // Only a full 14-bit input can exceed 9999; narrower inputs never overflow.
    generate
        if (WIDTH >= 14) begin : g_ovf
            assign w_ovf_in = (iVALUE > WIDTH'(9999));
        end else begin : g_no_ovf
            assign w_ovf_in = 1'b0;
        end
    endgenerate

    // Per-nibble add-3 correction, no inter-nibble carry.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                        ? r_bcd[4*gi +: 4] + 4'd3
                                        : r_bcd[4*gi +: 4];
        end
    endgenerate

    // Top nibble's MSB is shifted out, so only its low three bits matter.
    assign w_bcd_adj[14:12] = (r_bcd[15:12] >= 4'd5)
                            ? r_bcd[14:12] + 3'd3
                            : r_bcd[14:12];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (iSTART) w_state_nxt = c_CONV;
            c_CONV:  if (r_cnt == c_LAST) w_state_nxt = c_LOAD;
            c_LOAD:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != c_IDLE);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (iSTART) begin
                        r_bin <= iVALUE;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_ovf <= w_ovf_in;
                    end
                end
                c_CONV: begin
                    r_bcd <= {w_bcd_adj, r_bin[WIDTH-1]};
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + c_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Display registers move only on the LOAD edge, so no partial result shows.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_dig     <= 16'h0000;
            r_blank   <= 4'b1110;
            r_ovf_out <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == c_LOAD);
            if (r_state == c_LOAD) begin
                if (r_ovf) begin
                    r_dig     <= 16'hEEEE;
                    r_blank   <= 4'b0000;
                    r_ovf_out <= 1'b1;
                end else begin
                    r_dig      <= r_bcd;
                    r_blank[3] <= (r_bcd[15:12] == 4'd0);
                    r_blank[2] <= (r_bcd[15:8] == 8'd0);
                    r_blank[1] <= (r_bcd[15:4] == 12'd0);
                    r_blank[0] <= 1'b0;
                    r_ovf_out  <= 1'b0;
                end
            end
        end
    end

    assign oBUSY  = w_busy;
    assign oDONE  = r_done;
    assign oDIG3  = r_dig[15:12];
    assign oDIG2  = r_dig[11:8];
    assign oDIG1  = r_dig[7:4];
    assign oDIG0  = r_dig[3:0];
    assign oBLANK = r_blank;
    assign oOVF   = r_ovf_out;

endmodule
`default_nettype wire
